uart_rx: RTL and testbench

//  UART serial receiver; consumer of the 16x-oversampling tick from the baud

---
 rtl/uart_rx.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART serial receiver driven by a 16x-oversampling tick from the baud
// generator. The asynchronous rx line is brought into the clk domain through a
// two-flop synchroniser. The start bit is confirmed by sampling it at mid-bit.
// Data bits are shifted in LSB first. An optional parity bit is then checked,
// followed by the stop bit. Each received word is presented with a one-cycle
// done strobe.
//
// Parameters
//   DBIT     data bits per frame (5..8)
//   SB_TICK  s_tick count for the stop-bit window (16/24/32 = 1/1.5/2 stop bits)
//   PARITY   0 = none, 1 = odd, 2 = even
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   rx            serial input, asynchronous, idles high
//   s_tick        one-cycle strobe at 16x the baud rate
//   dout          last received data word
//   rx_done_tick  one-cycle pulse: dout / frame_err / parity_err are valid
//   frame_err     stop bit was sampled low in the last frame
//   parity_err    parity mismatch in the last frame (always 0 when PARITY=0)
//   busy          high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int PARITY  = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            parity_err,
   output logic            busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t          state_reg, state_next;
   logic [4:0]      s_cnt_reg, s_cnt_next;
   logic [2:0]      n_cnt_reg, n_cnt_next;
   logic [DBIT-1:0] shift_reg, shift_next;
   logic            par_bit_reg, par_bit_next;
   logic [DBIT-1:0] dout_reg, dout_next;
   logic            done_reg, done_next;
   logic            frame_err_reg, frame_err_next;
   logic            parity_err_reg, parity_err_next;
   logic            sync1_reg, sync2_reg;
   logic            rx_s;
   logic            par_xor;
   logic            par_mismatch;

   // Two-flop synchroniser; both stages reset to the idle (high) level so a
   // reset never looks like a start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
      end else begin
         sync1_reg <= rx;
         sync2_reg <= sync1_reg;
      end
   end

   assign rx_s = sync2_reg;

   // XOR over data and received parity bit: 1 means an odd number of ones.
   assign par_xor = (^shift_reg) ^ par_bit_reg;

   always_comb begin
      if (PARITY == 1)
         par_mismatch = ~par_xor;
      else if (PARITY == 2)
         par_mismatch = par_xor;
      else
         par_mismatch = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         s_cnt_reg      <= 5'd0;
         n_cnt_reg      <= 3'd0;
         shift_reg      <= '0;
         par_bit_reg    <= 1'b0;
         dout_reg       <= '0;
         done_reg       <= 1'b0;
         frame_err_reg  <= 1'b0;
         parity_err_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         s_cnt_reg      <= s_cnt_next;
         n_cnt_reg      <= n_cnt_next;
         shift_reg      <= shift_next;
         par_bit_reg    <= par_bit_next;
         dout_reg       <= dout_next;
         done_reg       <= done_next;
         frame_err_reg  <= frame_err_next;
         parity_err_reg <= parity_err_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      s_cnt_next      = s_cnt_reg;
      n_cnt_next      = n_cnt_reg;
      shift_next      = shift_reg;
      par_bit_next    = par_bit_reg;
      dout_next       = dout_reg;
      done_next       = 1'b0;
      frame_err_next  = frame_err_reg;
      parity_err_next = parity_err_reg;

      case (state_reg)
         IDLE: begin
            // s_tick is deliberately ignored here; the start edge alone
            // aligns the oversampling count to the incoming frame.
            if (!rx_s) begin
               state_next = START;
               s_cnt_next = 5'd0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_cnt_reg == 5'd7) begin
                  // Mid start bit: still low means a real frame, otherwise a
                  // glitch that is dropped without a strobe.
                  if (!rx_s) begin
                     state_next = DATA;
                     s_cnt_next = 5'd0;
                     n_cnt_next = 3'd0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  s_cnt_next = s_cnt_reg + 5'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_cnt_reg == 5'd15) begin
                  s_cnt_next = 5'd0;
                  shift_next = {rx_s, shift_reg[DBIT-1:1]};
                  if (n_cnt_reg == 3'(DBIT - 1))
                     state_next = (PARITY != 0) ? PAR : STOP;
                  else
                     n_cnt_next = n_cnt_reg + 3'd1;
               end else begin
                  s_cnt_next = s_cnt_reg + 5'd1;
               end
            end
         end
         PAR: begin
            if (s_tick) begin
               if (s_cnt_reg == 5'd15) begin
                  par_bit_next = rx_s;
                  s_cnt_next   = 5'd0;
                  state_next   = STOP;
               end else begin
                  s_cnt_next = s_cnt_reg + 5'd1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_cnt_reg == 5'(SB_TICK - 1)) begin
                  state_next      = IDLE;
                  dout_next       = shift_reg;
                  frame_err_next  = ~rx_s;
                  parity_err_next = par_mismatch;
                  done_next       = 1'b1;
               end else begin
                  s_cnt_next = s_cnt_reg + 5'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign dout         = dout_reg;
   assign rx_done_tick = done_reg;
   assign frame_err    = frame_err_reg;
   assign parity_err   = parity_err_reg;
   assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. One instance runs 8N1 (PARITY=0) and a second
// instance runs 8E1 (PARITY=2) on its own serial line. Frames are driven bit
// by bit with 16 s_ticks per bit, and one tick is issued every 4 clocks.
// ---------------------------------------------------------------------------
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       rx_p;
   logic       s_tick;
   logic [7:0] dout, dout_p;
   logic       rx_done_tick, rx_done_tick_p;
   logic       frame_err, frame_err_p;
   logic       parity_err, parity_err_p;
   logic       busy, busy_p;

   int n_vec = 0;
   int n_err = 0;

   int         done_cnt   = 0;
   int         done_cnt_p = 0;
   logic [7:0] cap_dout [0:63];

   always #5 clk = ~clk;

   uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .s_tick       (s_tick),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err),
      .parity_err   (parity_err),
      .busy         (busy)
   );

   uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_dut_p (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx_p),
      .s_tick       (s_tick),
      .dout         (dout_p),
      .rx_done_tick (rx_done_tick_p),
      .frame_err    (frame_err_p),
      .parity_err   (parity_err_p),
      .busy         (busy_p)
   );

   // Pulse counter: a strobe stuck high would be counted on every cycle.
   always @(negedge clk) begin
      if (rx_done_tick) begin
         if (done_cnt < 64) cap_dout[done_cnt] = dout;
         done_cnt = done_cnt + 1;
      end
      if (rx_done_tick_p) done_cnt_p = done_cnt_p + 1;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, got running, need finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (3) @(negedge clk);
         s_tick = 1'b1;
         @(negedge clk);
         s_tick = 1'b0;
      end
   endtask

   task automatic set_line(input bit sel, input logic v);
      if (sel) rx_p = v;
      else     rx   = v;
   endtask

   // Stop bit is held for 12 ticks and then forced high. The receiver
   // samples it at tick 8. The early release lets a low stop bit be seen as
   // a rejected glitch rather than a new start bit.
   task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop,
                             input bit use_par, input logic par);
      set_line(sel, 1'b0);
      tick_n(16);
      for (int b = 0; b < 8; b++) begin
         set_line(sel, d[b]);
         tick_n(16);
      end
      if (use_par) begin
         set_line(sel, par);
         tick_n(16);
      end
      set_line(sel, stop);
      tick_n(12);
      set_line(sel, 1'b1);
      tick_n(4);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_dout;
      logic       exp_ferr;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       exp_perr;
   } pvec_t;

   vec_t  vecs  [6];
   pvec_t pvecs [4];

   initial begin
      int d0;
      logic [7:0] last_dout;

      vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0};
      vecs[1] = '{8'hA3, 1'b0, 8'hA3, 1'b1};
      vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
      vecs[4] = '{8'h81, 1'b1, 8'h81, 1'b0};
      vecs[5] = '{8'h7E, 1'b0, 8'h7E, 1'b1};

      // Even parity: the ones in data plus the parity bit must be even.
      pvecs[0] = '{8'h03, 1'b1, 1'b1};
      pvecs[1] = '{8'h03, 1'b0, 1'b0};
      pvecs[2] = '{8'h07, 1'b1, 1'b0};
      pvecs[3] = '{8'h07, 1'b0, 1'b1};

      reset  = 1'b1;
      rx     = 1'b1;
      rx_p   = 1'b1;
      s_tick = 1'b0;
      repeat (4) @(negedge clk);
      check("reset dout", 32'(dout), 32'h00);
      check("reset busy", 32'(busy), 32'h0);
      check("reset frame_err", 32'(frame_err), 32'h0);
      check("reset parity_err", 32'(parity_err), 32'h0);
      check("reset done", 32'(rx_done_tick), 32'h0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Table-driven 8N1 frames
      for (int i = 0; i < 6; i++) begin
         d0 = done_cnt;
         send_frame(1'b0, vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
         check($sformatf("frame %0d done pulses", i), 32'(done_cnt - d0), 32'd1);
         check($sformatf("frame %0d dout", i), 32'(dout), 32'(vecs[i].exp_dout));
         check($sformatf("frame %0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
         check($sformatf("frame %0d parity_err", i), 32'(parity_err), 32'h0);
         check($sformatf("frame %0d busy after", i), 32'(busy), 32'h0);
      end
      last_dout = vecs[5].exp_dout;

      // Table-driven 8E1 frames on the parity instance
      for (int i = 0; i < 4; i++) begin
         d0 = done_cnt_p;
         send_frame(1'b1, pvecs[i].data, 1'b1, 1'b1, pvecs[i].par);
         check($sformatf("par %0d done pulses", i), 32'(done_cnt_p - d0), 32'd1);
         check($sformatf("par %0d dout", i), 32'(dout_p), 32'(pvecs[i].data));
         check($sformatf("par %0d parity_err", i), 32'(parity_err_p), 32'(pvecs[i].exp_perr));
         check($sformatf("par %0d frame_err", i), 32'(frame_err_p), 32'h0);
      end

      // Start-bit glitch: low for 4 ticks, then high
      d0 = done_cnt;
      rx = 1'b0;
      tick_n(4);
      check("glitch busy during", 32'(busy), 32'h1);
      rx = 1'b1;
      tick_n(16);
      check("glitch done pulses", 32'(done_cnt - d0), 32'd0);
      check("glitch busy after", 32'(busy), 32'h0);
      check("glitch dout kept", 32'(dout), 32'(last_dout));

      // Reset during data bit 4 of 0x3C
      d0 = done_cnt;
      last_dout = 8'h3C;
      rx = 1'b0;
      tick_n(16);
      for (int b = 0; b < 4; b++) begin
         rx = last_dout[b];
         tick_n(16);
      end
      rx = last_dout[4];
      tick_n(5);
      check("abort busy before reset", 32'(busy), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      check("abort dout", 32'(dout), 32'h00);
      check("abort busy", 32'(busy), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rx = 1'b1;
      tick_n(16);
      check("abort done pulses", 32'(done_cnt - d0), 32'd0);
      d0 = done_cnt;
      send_frame(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
      check("after abort done pulses", 32'(done_cnt - d0), 32'd1);
      check("after abort dout", 32'(dout), 32'h3C);

      // Back-to-back 0x00 then 0xFF with no idle time
      d0 = done_cnt;
      send_frame(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      check("b2b done pulses", 32'(done_cnt - d0), 32'd2);
      if (done_cnt >= d0 + 2 && d0 + 1 < 64) begin
         check("b2b first dout", 32'(cap_dout[d0]), 32'h00);
         check("b2b second dout", 32'(cap_dout[d0 + 1]), 32'hFF);
      end
      check("b2b frame_err", 32'(frame_err), 32'h0);
      check("b2b busy after", 32'(busy), 32'h0);

      // Break: 10 bit times low. The frame completes with dout=0 and
      // frame_err=1, and the FSM restarts immediately. The restarted frame
      // is confirmed in the low tail of the break. It then reads the
      // following high time as 0xFF with a good stop bit.
      d0 = done_cnt;
      rx = 1'b0;
      tick_n(160);
      check("break done pulses", 32'(done_cnt - d0), 32'd1);
      check("break dout", 32'(dout), 32'h00);
      check("break frame_err", 32'(frame_err), 32'h1);
      check("break busy restarted", 32'(busy), 32'h1);
      rx = 1'b1;
      tick_n(160);
      check("break recover done pulses", 32'(done_cnt - d0), 32'd2);
      check("break recover dout", 32'(dout), 32'hFF);
      check("break recover frame_err", 32'(frame_err), 32'h0);
      check("break recover busy", 32'(busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
